// File: rtl/stage_fe.sv
// Instruction fetch stage.
// Owns the fetch PC and issues word requests on a valid/ready channel.
// Fetched words go into a small FIFO that feeds the registered decode
// triple (out_inst/out_pc/out_flush).
// A redirect discards wrong-path requests, responses and buffered words.
module stage_fe #(
   parameter int                      INST_W      = 32,
   parameter int                      INST_ADDR_W = 32,
   parameter logic [INST_ADDR_W-1:0]  RESET_PC    = '0,
   parameter int                      FIFO_DEPTH  = 2,
   parameter logic [INST_W-1:0]       NOP_INST    = INST_W'(32'h0000_0013)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [INST_ADDR_W-1:0] redirect_pc,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [INST_ADDR_W-1:0] imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [INST_W-1:0]      imem_resp_data,
   output logic [INST_W-1:0]      out_inst,
   output logic [INST_ADDR_W-1:0] out_pc,
   output logic                   out_flush
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [INST_ADDR_W-1:0] fetch_pc;
   logic                   pend_q;
   logic                   pend_stale_q;
   logic [INST_ADDR_W-1:0] pend_addr_q;
   logic [CNT_W-1:0]       outstanding;
   logic [CNT_W-1:0]       outstanding_nxt;
   logic [CNT_W-1:0]       drop_cnt;
   logic [CNT_W-1:0]       fifo_count;
   logic [PTR_W-1:0]       ifq_wr;
   logic [PTR_W-1:0]       ifq_rd;
   logic [PTR_W-1:0]       fifo_wr;
   logic [PTR_W-1:0]       fifo_rd;

   // ifq_pc holds the PC of every in-flight request, in issue order, so
   // each response can be paired with its address.
   logic [INST_ADDR_W-1:0] ifq_pc    [FIFO_DEPTH];
   logic [INST_W-1:0]      fifo_inst [FIFO_DEPTH];
   logic [INST_ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];

   logic                   pop;
   logic                   push;
   logic                   accept;
   logic                   req_hold;
   logic                   raise_new;
   logic                   credit_ok;
   logic [CNT_W:0]         credit_used;

   // The two low bits of the redirect target are forced to zero.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Request/credit decode. The entry leaving the FIFO this cycle frees its
   // slot immediately, which lets a 1-cycle memory stream without bubbles.
   always_comb begin
      pop             = en && !stall && !redirect_valid && (fifo_count != '0);
      credit_used     = {1'b0, outstanding} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
      credit_ok       = credit_used < (CNT_W+1)'(FIFO_DEPTH);
      raise_new       = en && !redirect_valid && credit_ok;
      imem_req_valid  = !rst && (pend_q || raise_new);
      imem_req_addr   = pend_q ? pend_addr_q : fetch_pc;
      accept          = imem_req_valid && imem_req_ready;
      req_hold        = imem_req_valid && !imem_req_ready;
      push            = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
      outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(imem_resp_valid);
   end

   // Fetch PC, pending request, outstanding/drop accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc     <= RESET_PC;
         pend_q       <= 1'b0;
         pend_stale_q <= 1'b0;
         pend_addr_q  <= RESET_PC;
         outstanding  <= '0;
         drop_cnt     <= '0;
         ifq_wr       <= '0;
         ifq_rd       <= '0;
      end else begin
         pend_q <= req_hold;
         if (req_hold) begin
            pend_addr_q <= imem_req_addr;
         end
         // A request left pending across a redirect is wrong-path: it still
         // completes, but must not advance fetch_pc and its response is dropped.
         pend_stale_q <= req_hold && (redirect_valid || (pend_q && pend_stale_q));
         outstanding  <= outstanding_nxt;
         if (accept) begin
            ifq_wr <= ifq_wr + PTR_W'(1);
         end
         if (imem_resp_valid) begin
            ifq_rd <= ifq_rd + PTR_W'(1);
         end
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[INST_ADDR_W-1:2], 2'b00};
            drop_cnt <= outstanding_nxt + CNT_W'(req_hold);
         end else begin
            if (accept && !(pend_q && pend_stale_q)) begin
               fetch_pc <= fetch_pc + INST_ADDR_W'(4);
            end
            if (imem_resp_valid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - CNT_W'(1);
            end
         end
      end
   end

   // In-flight PC queue and instruction FIFO storage.
   always_ff @(posedge clk) begin
      if (accept) begin
         ifq_pc[ifq_wr] <= imem_req_addr;
      end
      if (push) begin
         fifo_inst[fifo_wr] <= imem_resp_data;
         fifo_pc[fifo_wr]   <= ifq_pc[ifq_rd];
      end
   end

   // Instruction FIFO pointers; a redirect empties it.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_wr <= fifo_wr + PTR_W'(1);
         end
         if (pop) begin
            fifo_rd <= fifo_rd + PTR_W'(1);
         end
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Decode-facing output registers; a redirect forces a bubble even when stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_flush <= 1'b1;
         out_inst  <= NOP_INST;
         out_pc    <= RESET_PC;
      end else if (redirect_valid) begin
         out_flush <= 1'b1;
         out_inst  <= NOP_INST;
      end else if (en && !stall) begin
         if (fifo_count != '0) begin
            out_flush <= 1'b0;
            out_inst  <= fifo_inst[fifo_rd];
            out_pc    <= fifo_pc[fifo_rd];
         end else begin
            out_flush <= 1'b1;
            out_inst  <= NOP_INST;
         end
      end
   end

endmodule

// File: tb/tb_stage_fe.sv
// Directed bench for stage_fe: fetch streaming, stall, memory back-pressure,
// redirects (plain and under stall) and mid-stream reset.
// Memory model answers in order with data equal to the request address.
module tb_stage_fe;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        en;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_flush;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int mem_lat  = 1;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   mreq_t       mhead;
   logic [31:0] acc_log[$];

   stage_fe dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_inst        (out_inst),
      .out_pc          (out_pc),
      .out_flush       (out_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // In-order memory: accepts sampled mid-cycle, answer mem_lat cycles later.
   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            mhead           = mq.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mhead.addr;
         end else begin
            imem_resp_valid = 1'b0;
         end
         @(negedge clk);
         if (rst) begin
            mq.delete();
         end else if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            acc_log.push_back(imem_req_addr);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Leaves the bench at the start of cycle 0 after reset release.
   task automatic do_reset();
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      en             = 1'b1;
      next_cycle();
      next_cycle();
      acc_log.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      next_cycle();
      next_cycle();
      sample();
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      n_checks++;
      if (out_flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush: got %b want 1", out_flush); end
      n_checks++;
      if (out_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", out_inst, NOP); end
      n_checks++;
      if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      next_cycle();
      acc_log.delete();
      rst = 1'b0;
   endtask

   // Cycles 0..4 after release: requests 4*c, out_pc 4*(c-3) from cycle 3.
   task automatic test_fetch();
      logic [31:0] exp_pc;
      for (int c = 0; c < 5; c++) begin
         sample();
         n_checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
            n_fail++;
            $display("FAIL fetch_req c=%0d: got v=%b a=%h want v=1 a=%h", c, imem_req_valid, imem_req_addr, 32'(4 * c));
         end
         if (c < 3) begin
            n_checks++;
            if (out_flush !== 1'b1) begin n_fail++; $display("FAIL fetch_bubble c=%0d: got %b want 1", c, out_flush); end
         end else begin
            exp_pc = 32'(4 * (c - 3));
            n_checks++;
            if (out_flush !== 1'b0 || out_pc !== exp_pc || out_inst !== exp_pc) begin
               n_fail++;
               $display("FAIL fetch_out c=%0d: got f=%b pc=%h inst=%h want f=0 pc=%h inst=%h", c, out_flush, out_pc, out_inst, exp_pc, exp_pc);
            end
         end
         next_cycle();
      end
   endtask

   // Continues from cycle 5 of test_fetch, where out_pc is 0x8.
   task automatic test_stall();
      int          n_beyond;
      logic [31:0] exp_pc;
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sample();
         n_checks++;
         if (out_flush !== 1'b0 || out_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_hold k=%0d: got f=%b pc=%h want f=0 pc=00000008", k, out_flush, out_pc);
         end
         n_checks++;
         if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_credit k=%0d: req_valid got %b want 0", k, imem_req_valid); end
         next_cycle();
      end
      n_beyond = 0;
      foreach (acc_log[i]) if (acc_log[i] > 32'h8) n_beyond++;
      n_checks++;
      if (n_beyond > 2) begin n_fail++; $display("FAIL stall_issued: got %0d requests past 0x8 want at most 2", n_beyond); end
      stall = 1'b0;
      for (int c = 10; c < 17; c++) begin
         sample();
         exp_pc = (c == 10) ? 32'h8 : 32'(12 + 4 * (c - 11));
         n_checks++;
         if (out_flush !== 1'b0 || out_pc !== exp_pc || out_inst !== exp_pc) begin
            n_fail++;
            $display("FAIL stall_resume c=%0d: got f=%b pc=%h inst=%h want f=0 pc=%h", c, out_flush, out_pc, out_inst, exp_pc);
         end
         next_cycle();
      end
   endtask

   task automatic test_ready_low();
      do_reset();
      repeat (4) next_cycle();
      imem_req_ready = 1'b0;
      for (int c = 4; c < 7; c++) begin
         sample();
         n_checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL ready_hold c=%0d: got v=%b a=%h want v=1 a=00000010", c, imem_req_valid, imem_req_addr);
         end
         if (c == 6) begin
            n_checks++;
            if (out_flush !== 1'b0 || out_pc !== 32'hC) begin n_fail++; $display("FAIL ready_drain: got f=%b pc=%h want f=0 pc=0000000c", out_flush, out_pc); end
         end
         next_cycle();
      end
      imem_req_ready = 1'b1;
      sample();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL ready_resume: got v=%b a=%h want v=1 a=00000010", imem_req_valid, imem_req_addr); end
      n_checks++;
      if (out_flush !== 1'b1 || out_inst !== NOP) begin n_fail++; $display("FAIL ready_bubble0: got f=%b inst=%h want f=1 inst=%h", out_flush, out_inst, NOP); end
      next_cycle();
      sample();
      n_checks++;
      if (imem_req_addr !== 32'h14 || out_flush !== 1'b1) begin n_fail++; $display("FAIL ready_next: got a=%h f=%b want a=00000014 f=1", imem_req_addr, out_flush); end
      next_cycle();
      sample();
      n_checks++;
      if (out_flush !== 1'b1) begin n_fail++; $display("FAIL ready_bubble2: got %b want 1", out_flush); end
      next_cycle();
      sample();
      n_checks++;
      if (out_flush !== 1'b0 || out_pc !== 32'h10) begin n_fail++; $display("FAIL ready_out: got f=%b pc=%h want f=0 pc=00000010", out_flush, out_pc); end
      next_cycle();
   endtask

   // 2-cycle memory: at cycle 2 both 0x0 and 0x4 are in flight.
   task automatic test_redirect();
      mem_lat = 2;
      do_reset();
      next_cycle();
      next_cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      n_checks++;
      if (out_flush !== 1'b1 || out_inst !== NOP) begin n_fail++; $display("FAIL redir_flush: got f=%b inst=%h want f=1 inst=%h", out_flush, out_inst, NOP); end
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
      for (int c = 4; c < 7; c++) begin
         next_cycle();
         sample();
         n_checks++;
         if (out_flush !== 1'b1) begin n_fail++; $display("FAIL redir_drop c=%0d: got f=%b pc=%h want f=1", c, out_flush, out_pc); end
      end
      next_cycle();
      sample();
      n_checks++;
      if (out_flush !== 1'b0 || out_pc !== 32'h100 || out_inst !== 32'h100) begin n_fail++; $display("FAIL redir_first: got f=%b pc=%h inst=%h want f=0 pc=00000100", out_flush, out_pc, out_inst); end
      next_cycle();
      sample();
      n_checks++;
      if (out_flush !== 1'b0 || out_pc !== 32'h104) begin n_fail++; $display("FAIL redir_second: got f=%b pc=%h want f=0 pc=00000104", out_flush, out_pc); end
      next_cycle();
      mem_lat = 1;
   endtask

   task automatic test_redirect_stall();
      bit found;
      do_reset();
      repeat (5) next_cycle();
      stall = 1'b1;
      next_cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      n_checks++;
      if (out_flush !== 1'b1 || out_inst !== NOP) begin n_fail++; $display("FAIL rstall_flush: got f=%b inst=%h want f=1 inst=%h", out_flush, out_inst, NOP); end
      next_cycle();
      next_cycle();
      stall = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         sample();
         if (out_flush === 1'b0) found = 1'b1;
         else next_cycle();
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL rstall_timeout: got no valid output within 10 cycles want one");
      end else begin
         n_checks++;
         if (out_pc !== 32'h200 || out_inst !== 32'h200) begin n_fail++; $display("FAIL rstall_target: got pc=%h inst=%h want 00000200", out_pc, out_inst); end
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (5) next_cycle();
      stall = 1'b1;
      next_cycle();
      next_cycle();
      sample();
      n_checks++;
      if (imem_req_valid !== 1'b0 || out_pc !== 32'h8) begin n_fail++; $display("FAIL rmid_full: got v=%b pc=%h want v=0 pc=00000008", imem_req_valid, out_pc); end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      sample();
      n_checks++;
      if (out_flush !== 1'b1 || out_pc !== 32'h0 || out_inst !== NOP) begin n_fail++; $display("FAIL rmid_out: got f=%b pc=%h inst=%h want f=1 pc=0 inst=%h", out_flush, out_pc, out_inst, NOP); end
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b want 0", imem_req_valid); end
      next_cycle();
      rst   = 1'b0;
      stall = 1'b0;
      sample();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_restart: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
      repeat (3) next_cycle();
      sample();
      n_checks++;
      if (out_flush !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin n_fail++; $display("FAIL rmid_first: got f=%b pc=%h inst=%h want f=0 pc=0", out_flush, out_pc, out_inst); end
      next_cycle();
   endtask

   initial begin
      rst            = 1'b1;
      en             = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      test_reset();
      test_fetch();
      test_stall();
      test_ready_low();
      test_redirect();
      test_redirect_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
